// File: rtl/d7s_seg_monitor.sv
// d7s_seg_monitor: debounces a sampled seven-segment pattern, decodes it back to a
// hex digit and flags illegal glyphs and digits that do not count up by one.
module d7s_seg_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter int MAX_DIGIT     = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       resync,
   input  logic [6:0] seg_in,
   output logic [3:0] digit,
   output logic       digit_valid,
   output logic       blank,
   output logic       code_err,
   output logic       step_err,
   output logic [7:0] err_count
);

   localparam int               CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);
   localparam logic [4:0]       MAX_D   = 5'(MAX_DIGIT);

   typedef enum logic {SYNC, TRACK} state_t;

   state_t           state_q, state_d;
   logic [6:0]       s, seg_q, last_pat, acc_pat;
   logic [CNT_W-1:0] stab_cnt;
   logic             accept, is_legal, step_bad;
   logic [3:0]       dec_val, digit_d;
   logic [4:0]       exp_val;
   logic             blank_d, valid_d, code_d, step_d;

   assign s = ACTIVE_LOW ? ~seg_in : seg_in;

   // With a single-cycle filter the pattern is accepted on the edge that captures it.
   always_comb begin
      accept  = 1'b0;
      acc_pat = seg_q;
      if (STABLE_CYCLES == 1) begin
         acc_pat = s;
         accept  = ena && (s != seg_q) && (s != last_pat);
      end else begin
         accept  = ena && (s == seg_q) && (stab_cnt == CNT_PRE) && (seg_q != last_pat);
      end
   end

   always_comb begin
      is_legal = 1'b1;
      dec_val  = 4'h0;
      case (acc_pat)
         7'h3F:   dec_val = 4'h0;
         7'h06:   dec_val = 4'h1;
         7'h5B:   dec_val = 4'h2;
         7'h4F:   dec_val = 4'h3;
         7'h66:   dec_val = 4'h4;
         7'h6D:   dec_val = 4'h5;
         7'h7D:   dec_val = 4'h6;
         7'h07:   dec_val = 4'h7;
         7'h7F:   dec_val = 4'h8;
         7'h6F:   dec_val = 4'h9;
         7'h77:   dec_val = 4'hA;
         7'h7C:   dec_val = 4'hB;
         7'h39:   dec_val = 4'hC;
         7'h5E:   dec_val = 4'hD;
         7'h79:   dec_val = 4'hE;
         7'h71:   dec_val = 4'hF;
         default: is_legal = 1'b0;
      endcase
   end

   // Successor is computed 5 bits wide so a digit of 15 never wraps to a false match.
   assign exp_val  = ({1'b0, digit} == MAX_D) ? 5'd0 : {1'b0, digit} + 5'd1;
   assign step_bad = ({1'b0, dec_val} != exp_val) || ({1'b0, dec_val} > MAX_D);

   always_comb begin
      state_d = state_q;
      digit_d = digit;
      blank_d = blank;
      valid_d = 1'b0;
      code_d  = 1'b0;
      step_d  = 1'b0;
      if (accept) begin
         if (acc_pat == 7'h00) begin
            blank_d = 1'b1;
         end else if (!is_legal) begin
            code_d  = 1'b1;
            blank_d = 1'b0;
            state_d = SYNC;
         end else begin
            digit_d = dec_val;
            valid_d = 1'b1;
            blank_d = 1'b0;
            if (state_q == SYNC) begin
               state_d = TRACK;
            end else if (!resync && step_bad) begin
               step_d = 1'b1;
            end
         end
      end
      if (ena && resync) begin
         state_d = SYNC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q    <= 7'h00;
         stab_cnt <= '0;
      end else if (ena) begin
         if (s != seg_q) begin
            seg_q    <= s;
            stab_cnt <= '0;
         end else if (stab_cnt != CNT_MAX) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
         end
      end
   end

   // Pulses are rebuilt every cycle, so they fall after one cycle even while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_pat    <= 7'h00;
         digit       <= 4'h0;
         blank       <= 1'b0;
         digit_valid <= 1'b0;
         code_err    <= 1'b0;
         step_err    <= 1'b0;
         err_count   <= 8'h00;
      end else begin
         digit_valid <= valid_d;
         code_err    <= code_d;
         step_err    <= step_d;
         digit       <= digit_d;
         blank       <= blank_d;
         if (accept) begin
            last_pat <= acc_pat;
         end
         if ((code_d || step_d) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_d7s_seg_monitor.sv
// tb_d7s_seg_monitor: two monitor instances (default, and active-low with a 1-cycle
// filter) driven from one logical pattern stream and compared to a run-length model.
module tb_d7s_seg_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       resync = 1'b0;
   logic [6:0] seg_pat = 7'h00;

   logic [3:0] digit0, digit1;
   logic       valid0, valid1, blank0, blank1, code0, code1, step0, step1;
   logic [7:0] err0, err1;

   int checks = 0;
   int passes = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   d7s_seg_monitor #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0), .MAX_DIGIT(7)) dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .resync(resync), .seg_in(seg_pat),
      .digit(digit0), .digit_valid(valid0), .blank(blank0), .code_err(code0),
      .step_err(step0), .err_count(err0)
   );

   d7s_seg_monitor #(.STABLE_CYCLES(1), .ACTIVE_LOW(1'b1), .MAX_DIGIT(9)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .resync(resync), .seg_in(~seg_pat),
      .digit(digit1), .digit_valid(valid1), .blank(blank1), .code_err(code1),
      .step_err(step1), .err_count(err1)
   );

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int         stable_p [2] = '{4, 1};
   int         max_p    [2] = '{7, 9};

   // Model tracks how many enabled edges the current pattern has been seen in a row.
   logic [6:0] m_held [2] = '{7'h00, 7'h00};
   logic [6:0] m_last [2] = '{7'h00, 7'h00};
   int         m_run  [2] = '{1, 1};
   int         m_digit[2] = '{0, 0};
   bit         m_blank[2] = '{0, 0};
   bit         m_valid[2] = '{0, 0};
   bit         m_code [2] = '{0, 0};
   bit         m_step [2] = '{0, 0};
   bit         m_track[2] = '{0, 0};
   int         m_err  [2] = '{0, 0};

   function automatic int lookupGlyph(input logic [6:0] p);
      for (int g = 0; g < 16; g++) begin
         if (glyph[g] == p) return g;
      end
      return -1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         m_held[i] = 7'h00; m_last[i] = 7'h00; m_run[i] = 1; m_digit[i] = 0;
         m_blank[i] = 0; m_valid[i] = 0; m_code[i] = 0; m_step[i] = 0;
         m_track[i] = 0; m_err[i] = 0;
      end
   endtask

   task automatic modelStep(input int i);
      int v;
      int next_v;
      m_valid[i] = 0;
      m_code[i]  = 0;
      m_step[i]  = 0;
      if (ena) begin
         if (seg_pat != m_held[i]) begin
            m_held[i] = seg_pat;
            m_run[i]  = 1;
         end else if (m_run[i] < 1000) begin
            m_run[i]++;
         end
         if (m_run[i] == stable_p[i] && m_held[i] != m_last[i]) begin
            m_last[i] = m_held[i];
            v = lookupGlyph(m_held[i]);
            if (m_held[i] == 7'h00) begin
               m_blank[i] = 1;
            end else if (v < 0) begin
               m_code[i]  = 1;
               m_blank[i] = 0;
               m_track[i] = 0;
            end else begin
               if (m_track[i] && !resync) begin
                  next_v = (m_digit[i] == max_p[i]) ? 0 : m_digit[i] + 1;
                  if (v != next_v || v > max_p[i]) m_step[i] = 1;
               end
               m_digit[i] = v;
               m_valid[i] = 1;
               m_blank[i] = 0;
               m_track[i] = 1;
            end
            if ((m_code[i] || m_step[i]) && m_err[i] < 255) m_err[i]++;
         end
         if (resync) m_track[i] = 0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         modelReset();
      end else begin
         for (int i = 0; i < 2; i++) modelStep(i);
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
      end else begin
         passes++;
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("digit0", 8'(digit0), 8'(m_digit[0]));
         checkOutput("valid0", 8'(valid0), 8'(m_valid[0]));
         checkOutput("blank0", 8'(blank0), 8'(m_blank[0]));
         checkOutput("code0",  8'(code0),  8'(m_code[0]));
         checkOutput("step0",  8'(step0),  8'(m_step[0]));
         checkOutput("err0",   err0,       8'(m_err[0]));
         checkOutput("digit1", 8'(digit1), 8'(m_digit[1]));
         checkOutput("valid1", 8'(valid1), 8'(m_valid[1]));
         checkOutput("blank1", 8'(blank1), 8'(m_blank[1]));
         checkOutput("code1",  8'(code1),  8'(m_code[1]));
         checkOutput("step1",  8'(step1),  8'(m_step[1]));
         checkOutput("err1",   err1,       8'(m_err[1]));
      end
   end

   task automatic applyStimulus(input logic [6:0] pat, input logic en, input logic rs);
      @(posedge clk);
      #2;
      seg_pat = pat;
      ena     = en;
      resync  = rs;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(seg_pat, ena, 1'b0);
   endtask

   // Holds a pattern until the default instance reports it; returns 1 time unit after that edge.
   task automatic holdPattern(input logic [6:0] pat);
      applyStimulus(pat, 1'b1, 1'b0);
      idle(3);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] pat;
      int         seq_d;
      int         r;
      int         hold;

      @(posedge clk);
      check_en = 1'b1;

      // T1: reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_digit", 8'(digit0), 8'h00);
      checkOutput("rst_valid", 8'(valid0), 8'h00);
      checkOutput("rst_blank", 8'(blank0), 8'h00);
      checkOutput("rst_err",   err0,       8'h00);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // T2: 0 then 1, with exact accept latency
      applyStimulus(7'h3F, 1'b1, 1'b0);
      idle(2);
      checkOutput("t2_early_valid", 8'(valid0), 8'h00);
      idle(1);
      @(posedge clk);
      #1;
      checkOutput("t2_valid0", 8'(valid0), 8'h01);
      checkOutput("t2_digit0", 8'(digit0), 8'h00);
      holdPattern(7'h06);
      checkOutput("t2_valid1", 8'(valid0), 8'h01);
      checkOutput("t2_digit1", 8'(digit0), 8'h01);
      checkOutput("t2_step",   8'(step0),  8'h00);

      // T3: resync, then 7 -> 0 wraps cleanly
      applyStimulus(7'h06, 1'b1, 1'b1);
      holdPattern(7'h07);
      checkOutput("t3_digit7", 8'(digit0), 8'h07);
      holdPattern(7'h3F);
      checkOutput("t3_wrap_digit", 8'(digit0), 8'h00);
      checkOutput("t3_wrap_step",  8'(step0),  8'h00);

      // T4: glitch is ignored, then 1 -> 3 is a step error
      holdPattern(7'h06);
      applyStimulus(7'h5B, 1'b1, 1'b0);
      applyStimulus(7'h5B, 1'b1, 1'b0);
      applyStimulus(7'h06, 1'b1, 1'b0);
      idle(5);
      checkOutput("t4_glitch_digit", 8'(digit0), 8'h01);
      holdPattern(7'h4F);
      checkOutput("t4_step",  8'(step0),  8'h01);
      checkOutput("t4_digit", 8'(digit0), 8'h03);
      checkOutput("t4_err",   err0,       8'h01);

      // T5: illegal glyph, resynchronise on 4, then saturate the error counter
      holdPattern(7'h49);
      checkOutput("t5_code",  8'(code0),  8'h01);
      checkOutput("t5_digit", 8'(digit0), 8'h03);
      checkOutput("t5_err",   err0,       8'h02);
      holdPattern(7'h66);
      checkOutput("t5_digit4", 8'(digit0), 8'h04);
      checkOutput("t5_step4",  8'(step0),  8'h00);
      for (int k = 0; k < 150; k++) begin
         holdPattern(7'h49);
         holdPattern(7'h01);
      end
      checkOutput("t5_sat", err0, 8'hFF);
      holdPattern(7'h00);
      checkOutput("t5_blank", 8'(blank0), 8'h01);
      checkOutput("t5_blank_valid", 8'(valid0), 8'h00);

      // T6: ena low mid-filter freezes everything
      applyStimulus(7'h6D, 1'b1, 1'b0);
      applyStimulus(7'h6D, 1'b1, 1'b0);
      repeat (10) applyStimulus(7'h6D, 1'b0, 1'b0);
      checkOutput("t6_frozen_digit", 8'(digit0), 8'h04);
      checkOutput("t6_frozen_blank", 8'(blank0), 8'h01);
      applyStimulus(7'h6D, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("t6_not_yet", 8'(valid0), 8'h00);
      @(posedge clk);
      #1;
      checkOutput("t6_valid", 8'(valid0), 8'h01);
      checkOutput("t6_digit", 8'(digit0), 8'h05);
      checkOutput("t6_al_digit", 8'(digit1), 8'h05);

      // Reset in the middle of filtering
      applyStimulus(7'h79, 1'b1, 1'b0);
      applyStimulus(7'h79, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_err",   err0,       8'h00);
      checkOutput("mid_rst_digit", 8'(digit0), 8'h00);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Randomised phase: mostly in-order counting with glitches, errors and gaps
      seq_d = 0;
      for (int n = 0; n < 500; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            pat   = glyph[seq_d];
            seq_d = (seq_d == 7) ? 0 : seq_d + 1;
         end else if (r == 6) begin
            pat = glyph[$urandom_range(0, 15)];
         end else if (r == 7) begin
            pat = 7'($urandom);
         end else if (r == 8) begin
            pat = 7'h00;
         end else begin
            pat = seg_pat ^ 7'(1 << $urandom_range(0, 6));
         end
         hold = $urandom_range(1, 7);
         for (int h = 0; h < hold; h++) begin
            applyStimulus(pat, ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
         end
      end
      idle(6);
      @(negedge clk);
      #1;
      check_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
